lv_pwm_burst_decode: RTL

//  Parametrised PWM interrupt-line decoder on the LV side. Measures high pulses on the HV->LV PWM wire and

---
 rtl/lv_pwm_burst_decode.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/lv_pwm_burst_decode.sv
// LV-side PWM interrupt-line decoder: qualifies high pulses, groups them into bursts, emits burst codes and drives o_intb_n.
// Optional build macro PWM_BURST_STAT_EN adds i_stat_clr and the saturating strobe counters o_code_cnt/o_err_cnt.
module lv_pwm_burst_decode #(
  parameter int PW_MIN   = 4,
  parameter int PW_MAX   = 8,
  parameter int GAP_CYC  = 9,
  parameter int MAX_CODE = 4,
  parameter int SET_CODE = 1,
  parameter int CLR_CODE = 4,
  parameter int CODE_W   = $clog2(MAX_CODE + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pwm,
  output logic              o_pwm_gwave,
  output logic [CODE_W-1:0] o_code,
  output logic              o_code_vld,
  output logic              o_err,
  output logic              o_intb_n
`ifdef PWM_BURST_STAT_EN
  ,
  input  logic              i_stat_clr,
  output logic [15:0]       o_code_cnt,
  output logic [15:0]       o_err_cnt
`endif
);

  // state   | meaning
  // S_IDLE  | no burst in progress
  // S_GAP   | counting pulses of a burst, waiting for the terminating gap
  // S_ABORT | error seen, discard until GAP_CYC consecutive lows
  typedef enum logic [1:0] {S_IDLE, S_GAP, S_ABORT} state_t;

  localparam int HI_W = $clog2(PW_MAX + 2);
  localparam int LO_W = $clog2(GAP_CYC + 1);

  localparam logic [HI_W-1:0]   C_PW_MIN   = HI_W'(PW_MIN);
  localparam logic [HI_W-1:0]   C_PW_MAX   = HI_W'(PW_MAX);
  localparam logic [HI_W-1:0]   C_HI_SAT   = HI_W'(PW_MAX + 1);
  localparam logic [LO_W-1:0]   C_GAP      = LO_W'(GAP_CYC);
  localparam logic [LO_W-1:0]   C_GAP_M1   = LO_W'(GAP_CYC - 1);
  localparam logic [CODE_W-1:0] C_MAX_CODE = CODE_W'(MAX_CODE);
  localparam logic [CODE_W-1:0] C_SET      = CODE_W'(SET_CODE);
  localparam logic [CODE_W-1:0] C_CLR      = CODE_W'(CLR_CODE);

  logic              r_sync1;
  logic              r_sync2;
  logic [HI_W-1:0]   r_hi_cnt;
  logic [LO_W-1:0]   r_lo_cnt;
  logic [CODE_W-1:0] r_bit_cnt;
  logic [CODE_W-1:0] r_code;
  logic              r_code_vld;
  logic              r_err;
  logic              r_intb_n;
  state_t            r_state;

  logic w_fall;
  logic w_bit;
  logic w_ovl;
  logic w_gap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pwm;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi_cnt <= '0;
      r_lo_cnt <= '0;
    end else if (r_sync2) begin
      r_lo_cnt <= '0;
      if (r_hi_cnt != C_HI_SAT) r_hi_cnt <= r_hi_cnt + 1'b1;
    end else begin
      r_hi_cnt <= '0;
      if (r_lo_cnt != C_GAP) r_lo_cnt <= r_lo_cnt + 1'b1;
    end
  end

  // r_hi_cnt still holds the finished pulse width on the first low cycle
  assign w_fall = !r_sync2 && (r_hi_cnt != '0);
  assign w_bit  = w_fall && (r_hi_cnt >= C_PW_MIN) && (r_hi_cnt <= C_PW_MAX);
  assign w_ovl  = r_sync2 && (r_hi_cnt == C_PW_MAX);
  assign w_gap  = !r_sync2 && (r_lo_cnt >= C_GAP_M1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_code     <= '0;
      r_code_vld <= 1'b0;
      r_err      <= 1'b0;
      r_intb_n   <= 1'b1;
    end else begin
      r_code_vld <= 1'b0;
      r_err      <= 1'b0;
      if (r_code_vld) begin
        if (r_code == C_SET)      r_intb_n <= 1'b0;
        else if (r_code == C_CLR) r_intb_n <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_ovl) begin
            r_err     <= 1'b1;
            r_bit_cnt <= '0;
            r_state   <= S_ABORT;
          end else if (w_bit) begin
            r_bit_cnt <= CODE_W'(1);
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (w_ovl) begin
            r_err     <= 1'b1;
            r_bit_cnt <= '0;
            r_state   <= S_ABORT;
          end else if (w_bit) begin
            if (r_bit_cnt == C_MAX_CODE) begin
              r_err     <= 1'b1;
              r_bit_cnt <= '0;
              r_state   <= S_ABORT;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else if (w_gap) begin
            r_code     <= r_bit_cnt;
            r_code_vld <= 1'b1;
            r_bit_cnt  <= '0;
            r_state    <= S_IDLE;
          end
        end
        S_ABORT: begin
          r_bit_cnt <= '0;
          if (w_gap) r_state <= S_IDLE;
        end
        default: begin
          r_bit_cnt <= '0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PWM_BURST_STAT_EN
  logic [15:0] r_code_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_code_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (i_stat_clr) begin
      r_code_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (r_code_vld && (r_code_cnt != 16'hFFFF)) r_code_cnt <= r_code_cnt + 16'd1;
      if (r_err && (r_err_cnt != 16'hFFFF))       r_err_cnt  <= r_err_cnt + 16'd1;
    end
  end

  assign o_code_cnt = r_code_cnt;
  assign o_err_cnt  = r_err_cnt;
`endif

  assign o_pwm_gwave = r_sync2;
  assign o_code      = r_code;
  assign o_code_vld  = r_code_vld;
  assign o_err       = r_err;
  assign o_intb_n    = r_intb_n;

endmodule
